// File: rtl/input_repeat_bank.sv
// input_repeat_bank: per-channel key command pulses (one-shot or DAS repeat)
// with last-input-wins SOCD resolution on one opposing channel pair.
module input_repeat_bank #(
  parameter int unsigned     N_CH        = 8,
  parameter int unsigned     TW          = 6,
  parameter logic [N_CH-1:0] REPEAT_MASK = 8'b0000_0111,
  parameter bit              PAIR_EN     = 1'b1,
  parameter int unsigned     PAIR_A      = 0,
  parameter int unsigned     PAIR_B      = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick_game,
  input  logic            enable,
  input  logic [N_CH-1:0] raw,
  input  logic [TW-1:0]   das_delay,
  input  logic [TW-1:0]   das_period,
  output logic [N_CH-1:0] cmd,
  output logic [N_CH-1:0] held
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } state_e;

  logic [N_CH-1:0] eff;
  logic [N_CH-1:0] held_q;
  logic [N_CH-1:0] cmd_q;
  logic [N_CH-1:0] cmd_d;
  logic [N_CH-1:0] press;
  logic            w_q;
  logic            w_d;
  logic            rawa_q;
  logic            rawb_q;
  logic            rise_a;
  logic            rise_b;

  // SOCD winner update and effective level derivation (uses next winner)
  always_comb begin
    rise_a = raw[PAIR_A] & ~rawa_q;
    rise_b = raw[PAIR_B] & ~rawb_q;
    w_d    = w_q;
    eff    = raw;
    if (PAIR_EN) begin
      if (rise_a)      w_d = 1'b0;
      else if (rise_b) w_d = 1'b1;
      eff[PAIR_A] = raw[PAIR_A] & (~raw[PAIR_B] | ~w_d);
      eff[PAIR_B] = raw[PAIR_B] & (~raw[PAIR_A] | w_d);
    end
  end

  assign press = eff & ~held_q;

  // Level history, winner and command registers; history keeps
  // tracking while disabled so a held key never fires on re-enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q <= '0;
      cmd_q  <= '0;
      w_q    <= 1'b0;
      rawa_q <= 1'b0;
      rawb_q <= 1'b0;
    end else begin
      held_q <= eff;
      cmd_q  <= cmd_d;
      w_q    <= w_d;
      rawa_q <= raw[PAIR_A];
      rawb_q <= raw[PAIR_B];
    end
  end

  assign cmd  = cmd_q;
  assign held = held_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    if (REPEAT_MASK[i]) begin : g_rep
      state_e        st_q;
      state_e        st_d;
      logic [TW-1:0] t_q;
      logic [TW-1:0] t_d;
      logic          c_d;

      // Repeat FSM state and timer registers
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          st_q <= S_IDLE;
          t_q  <= '0;
        end else begin
          st_q <= st_d;
          t_q  <= t_d;
        end
      end

      // DAS sequencing: press restarts, tick advances, low level idles
      always_comb begin
        st_d = st_q;
        t_d  = t_q;
        c_d  = 1'b0;
        if (!enable || !eff[i]) begin
          st_d = S_IDLE;
          t_d  = '0;
        end else if (press[i]) begin
          c_d  = 1'b1;
          t_d  = '0;
          st_d = S_DELAY;
        end else if (tick_game) begin
          unique case (st_q)
            S_DELAY: begin
              if (t_q >= das_delay) begin
                c_d  = 1'b1;
                t_d  = '0;
                st_d = S_REPEAT;
              end else begin
                t_d = t_q + TW'(1);
              end
            end
            S_REPEAT: begin
              if (t_q >= das_period) begin
                c_d = 1'b1;
                t_d = '0;
              end else begin
                t_d = t_q + TW'(1);
              end
            end
            default: begin
              st_d = st_q;
            end
          endcase
        end
      end

      assign cmd_d[i] = c_d;
    end else begin : g_one
      assign cmd_d[i] = press[i] & enable;
    end
  end

endmodule

// File: tb/tb_input_repeat_bank.sv
// Directed bench for input_repeat_bank; expected command vectors are
// queued as stimulus is driven and checked when the DUT registers them.
module tb_input_repeat_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_game;
  logic       enable;
  logic [7:0] raw;
  logic [5:0] das_delay;
  logic [5:0] das_period;
  logic [7:0] cmd;
  logic [7:0] held;

  logic [7:0] exp_q[$];
  int         nvec = 0;
  int         nerr = 0;

  input_repeat_bank dut (
    .clk(clk),
    .rst(rst),
    .tick_game(tick_game),
    .enable(enable),
    .raw(raw),
    .das_delay(das_delay),
    .das_period(das_period),
    .cmd(cmd),
    .held(held)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic [7:0] r, input logic tk,
                     input logic [7:0] e);
    logic [7:0] x;
    raw       = r;
    tick_game = tk;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    nvec++;
    assert (cmd === x) else begin
      nerr++;
      $error("FAIL cmd got=%h exp=%h t=%0t", cmd, x, $time);
    end
  endtask

  task automatic chk_held(input string tag, input logic [7:0] e);
    nvec++;
    assert (held === e) else begin
      nerr++;
      $error("FAIL %s held got=%h exp=%h", tag, held, e);
    end
  endtask

  function automatic bit fires(input int j, input int d, input int p);
    if (j == d + 1) return 1'b1;
    if (j > d + 1 && ((j - d - 1) % (p + 1)) == 0) return 1'b1;
    return 1'b0;
  endfunction

  // n ticks spaced 4 cycles apart; channels in m follow the DAS schedule
  task automatic ticks(input int n, input logic [7:0] r,
                       input logic [7:0] m, input int d, input int p);
    for (int j = 1; j <= n; j++) begin
      cyc(r, 1'b0, 8'h00);
      cyc(r, 1'b0, 8'h00);
      cyc(r, 1'b0, 8'h00);
      cyc(r, 1'b1, fires(j, d, p) ? m : 8'h00);
    end
  endtask

  initial begin
    rst        = 1'b1;
    tick_game  = 1'b0;
    enable     = 1'b1;
    raw        = '0;
    das_delay  = 6'd6;
    das_period = 6'd2;
    #23;
    nvec++;
    assert (cmd === 8'h00 && held === 8'h00) else begin
      nerr++;
      $error("FAIL reset got=%h/%h exp=00/00", cmd, held);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // one-shot channel 3
    cyc(8'h08, 1'b0, 8'h08);
    for (int i = 0; i < 200; i++) cyc(8'h08, (i % 20) == 19, 8'h00);
    chk_held("oneshot", 8'h08);
    cyc(8'h00, 1'b0, 8'h00);

    // DAS channel 0: delay 6, period 2
    cyc(8'h01, 1'b0, 8'h01);
    ticks(20, 8'h01, 8'h01, 6, 2);
    cyc(8'h00, 1'b1, 8'h00);
    ticks(3, 8'h00, 8'h00, 0, 0);

    // soft drop channel 2: delay 0, period 0
    das_delay  = 6'd0;
    das_period = 6'd0;
    cyc(8'h04, 1'b1, 8'h04);
    cyc(8'h04, 1'b1, 8'h04);
    cyc(8'h04, 1'b1, 8'h04);
    cyc(8'h04, 1'b0, 8'h00);
    cyc(8'h04, 1'b1, 8'h04);
    cyc(8'h00, 1'b0, 8'h00);
    das_delay  = 6'd6;
    das_period = 6'd2;

    // SOCD: hold A, then press B
    cyc(8'h01, 1'b0, 8'h01);
    cyc(8'h01, 1'b1, 8'h00);
    cyc(8'h03, 1'b0, 8'h02);
    chk_held("socd_b", 8'h02);
    ticks(10, 8'h03, 8'h02, 6, 2);
    cyc(8'h01, 1'b0, 8'h01);
    chk_held("socd_a", 8'h01);
    ticks(8, 8'h01, 8'h01, 6, 2);
    cyc(8'h00, 1'b0, 8'h00);
    cyc(8'h03, 1'b0, 8'h01);
    chk_held("socd_tie", 8'h01);
    cyc(8'h00, 1'b0, 8'h00);

    // enable drop while repeating, then re-enable with key held
    cyc(8'h01, 1'b0, 8'h01);
    ticks(10, 8'h01, 8'h01, 6, 2);
    enable = 1'b0;
    cyc(8'h01, 1'b1, 8'h00);
    cyc(8'h01, 1'b1, 8'h00);
    enable = 1'b1;
    cyc(8'h01, 1'b1, 8'h00);
    cyc(8'h01, 1'b0, 8'h00);
    ticks(8, 8'h01, 8'h00, 0, 0);
    cyc(8'h00, 1'b0, 8'h00);

    // live config: period 10 lowered to 1 with t = 5
    das_delay  = 6'd0;
    das_period = 6'd10;
    cyc(8'h01, 1'b0, 8'h01);
    cyc(8'h01, 1'b1, 8'h01);
    for (int i = 0; i < 5; i++) cyc(8'h01, 1'b1, 8'h00);
    das_period = 6'd1;
    cyc(8'h01, 1'b1, 8'h01);
    cyc(8'h01, 1'b1, 8'h00);
    cyc(8'h01, 1'b1, 8'h01);

    // async reset mid-repeat (period 0, cmd high before reset)
    das_period = 6'd0;
    cyc(8'h01, 1'b1, 8'h01);
    #3;
    rst = 1'b1;
    #1;
    nvec++;
    assert (cmd === 8'h00 && held === 8'h00) else begin
      nerr++;
      $error("FAIL async_rst got=%h/%h exp=00/00", cmd, held);
    end
    #2;
    rst = 1'b0;
    cyc(8'h01, 1'b0, 8'h01);
    cyc(8'h01, 1'b0, 8'h00);
    chk_held("post_rst", 8'h01);
    cyc(8'h00, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
